// File: rtl/obstacle_scheduler.sv
// Game-phase sequencer driving the obstacle mux select from vsync frame ticks.
// Optional build macro OBSTACLE_SCHEDULER_LFSR_EN selects pseudo-random obstacle order.
module obstacle_scheduler #(
  parameter int         NUM_OBSTACLES    = 2,
  parameter int         NUM_PHASES       = 8,
  parameter int         FRAMES_PER_PHASE = 600,
  parameter int         GAP_FRAMES       = 60,
  parameter logic [3:0] GAP_SELECT       = 4'd15
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       play_selected,
  input  logic       game_over,
  output logic [3:0] obstacle_select,
  output logic       phase_active,
  output logic [7:0] phase_num,
  output logic       victory
);

  typedef enum logic [2:0] {IDLE, GAP, ACTIVE, VICTORY, LOST} state_t;

  state_t      state_reg;
  logic        vsync_reg;
  logic        tick;
  logic [15:0] frame_reg;
  logic [3:0]  index_reg;
  logic [3:0]  index_rr;
  logic [3:0]  index_next;

  assign tick     = vsync_in & ~vsync_reg;
  assign index_rr = (index_reg == 4'(NUM_OBSTACLES - 1)) ? 4'd0 : index_reg + 4'd1;

`ifdef OBSTACLE_SCHEDULER_LFSR_EN
  logic [7:0] lfsr_reg;
  logic [7:0] lfsr_mod;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) lfsr_reg <= 8'hA5;
    else      lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
  end

  // Fall back to the round-robin successor so an obstacle never repeats back to back.
  assign lfsr_mod   = lfsr_reg % 8'(NUM_OBSTACLES);
  assign index_next = (lfsr_mod == {4'd0, index_reg}) ? index_rr : lfsr_mod[3:0];
`else
  assign index_next = index_rr;
`endif

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      vsync_reg       <= 1'b0;
      frame_reg       <= 16'd0;
      index_reg       <= 4'd0;
      obstacle_select <= GAP_SELECT;
      phase_active    <= 1'b0;
      phase_num       <= 8'd0;
      victory         <= 1'b0;
    end else begin
      vsync_reg <= vsync_in;
      case (state_reg)
        IDLE: begin
          // A tick arriving with play_selected is deliberately not counted.
          if (play_selected) begin
            state_reg <= GAP;
            frame_reg <= 16'd0;
            index_reg <= 4'd0;
            phase_num <= 8'd0;
          end
        end
        GAP, ACTIVE: begin
          if (!play_selected) begin
            state_reg       <= IDLE;
            frame_reg       <= 16'd0;
            index_reg       <= 4'd0;
            obstacle_select <= GAP_SELECT;
            phase_active    <= 1'b0;
            phase_num       <= 8'd0;
            victory         <= 1'b0;
          end else if (game_over) begin
            state_reg       <= LOST;
            frame_reg       <= 16'd0;
            obstacle_select <= GAP_SELECT;
            phase_active    <= 1'b0;
          end else if (tick) begin
            if (state_reg == GAP) begin
              if (frame_reg == 16'(GAP_FRAMES - 1)) begin
                state_reg       <= ACTIVE;
                frame_reg       <= 16'd0;
                obstacle_select <= index_reg;
                phase_active    <= 1'b1;
              end else begin
                frame_reg <= frame_reg + 16'd1;
              end
            end else if (frame_reg == 16'(FRAMES_PER_PHASE - 1)) begin
              frame_reg       <= 16'd0;
              obstacle_select <= GAP_SELECT;
              phase_active    <= 1'b0;
              if (phase_num == 8'(NUM_PHASES - 1)) begin
                state_reg <= VICTORY;
                victory   <= 1'b1;
              end else begin
                state_reg <= GAP;
                phase_num <= phase_num + 8'd1;
                index_reg <= index_next;
              end
            end else begin
              frame_reg <= frame_reg + 16'd1;
            end
          end
        end
        VICTORY, LOST: begin
          if (!play_selected) begin
            state_reg       <= IDLE;
            frame_reg       <= 16'd0;
            index_reg       <= 4'd0;
            obstacle_select <= GAP_SELECT;
            phase_active    <= 1'b0;
            phase_num       <= 8'd0;
            victory         <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler with a frame-level reference model.
// Building with OBSTACLE_SCHEDULER_LFSR_EN runs the random-order scenario instead.
module tb_obstacle_scheduler;

`ifdef OBSTACLE_SCHEDULER_LFSR_EN
  localparam int NO = 4;
  localparam int NP = 20;
`else
  localparam int NO = 2;
  localparam int NP = 2;
`endif
  localparam int FPP = 3;
  localparam int GF  = 2;

  logic       pclk = 1'b0;
  logic       rst = 1'b0;
  logic       vsync_in = 1'b0;
  logic       play_selected = 1'b0;
  logic       game_over = 1'b0;
  logic [3:0] obstacle_select;
  logic       phase_active;
  logic [7:0] phase_num;
  logic       victory;

  int checks = 0;
  int errors = 0;

  obstacle_scheduler #(
    .NUM_OBSTACLES(NO), .NUM_PHASES(NP), .FRAMES_PER_PHASE(FPP),
    .GAP_FRAMES(GF), .GAP_SELECT(4'd15)
  ) dut (
    .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .play_selected(play_selected),
    .game_over(game_over), .obstacle_select(obstacle_select),
    .phase_active(phase_active), .phase_num(phase_num), .victory(victory)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // One vsync pulse: high for one cycle, then low; ends on a falling clock edge.
  task automatic frame(input int n);
    repeat (n) begin
      @(negedge pclk) vsync_in = 1'b1;
      @(negedge pclk) vsync_in = 1'b0;
      @(negedge pclk);
    end
  endtask

  task automatic expect_out(input string name, input logic [3:0] s, input logic pa,
                            input logic [7:0] pn, input logic v);
    checks++;
    if (obstacle_select !== s || phase_active !== pa || phase_num !== pn || victory !== v) begin
      errors++;
      $display("FAIL %s: got sel=%0d act=%0b phase=%0d vic=%0b, want sel=%0d act=%0b phase=%0d vic=%0b",
               name, obstacle_select, phase_active, phase_num, victory, s, pa, pn, v);
    end else begin
      $display("ok   %s: sel=%0d act=%0b phase=%0d vic=%0b", name, s, pa, pn, v);
    end
  endtask

`ifndef OBSTACLE_SCHEDULER_LFSR_EN
  // Reference model: mode 0 idle, 1 gap, 2 active, 3 victory, 4 lost; frames counted 1-based.
  int m_mode, m_frames, m_phase, m_idx;
  bit m_vs_prev;

  always @(posedge pclk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_frames = 0; m_phase = 0; m_idx = 0; m_vs_prev = 0;
    end else begin
      bit t;
      int limit;
      t = vsync_in && !m_vs_prev;
      m_vs_prev = vsync_in;
      if (m_mode == 0) begin
        if (play_selected) begin m_mode = 1; m_frames = 0; m_phase = 0; m_idx = 0; end
      end else if (m_mode >= 3) begin
        if (!play_selected) begin m_mode = 0; m_phase = 0; end
      end else if (!play_selected) begin
        m_mode = 0; m_phase = 0;
      end else if (game_over) begin
        m_mode = 4;
      end else if (t) begin
        m_frames++;
        limit = (m_mode == 1) ? GF : FPP;
        if (m_frames == limit) begin
          m_frames = 0;
          if (m_mode == 1) m_mode = 2;
          else if (m_phase == NP - 1) m_mode = 3;
          else begin m_phase++; m_idx = (m_idx + 1) % NO; m_mode = 1; end
        end
      end
    end
  end

  always @(negedge pclk) begin
    logic [3:0] es;
    es = (m_mode == 2) ? 4'(m_idx) : 4'd15;
    checks++;
    if (obstacle_select !== es || phase_active !== (m_mode == 2) ||
        phase_num !== 8'(m_phase) || victory !== (m_mode == 3)) begin
      errors++;
      $display("FAIL model t=%0t: got sel=%0d act=%0b phase=%0d vic=%0b, want sel=%0d act=%0b phase=%0d vic=%0b",
               $time, obstacle_select, phase_active, phase_num, victory,
               es, (m_mode == 2), m_phase, (m_mode == 3));
    end
  end

  initial begin
    cyc(3);
    expect_out("reset", 4'd15, 0, 8'd0, 0);
    rst = 1'b1;
    cyc(2);
    expect_out("idle_after_reset", 4'd15, 0, 8'd0, 0);
    play_selected = 1'b1;
    cyc(1);
    expect_out("gap0", 4'd15, 0, 8'd0, 0);
    frame(1);
    expect_out("gap0_one_tick", 4'd15, 0, 8'd0, 0);
    frame(1);
    expect_out("active0", 4'd0, 1, 8'd0, 0);
    frame(3);
    expect_out("gap1", 4'd15, 0, 8'd1, 0);
    frame(2);
    expect_out("active1", 4'd1, 1, 8'd1, 0);
    frame(3);
    expect_out("victory", 4'd15, 0, 8'd1, 1);
    game_over = 1'b1; cyc(1); game_over = 1'b0; frame(2);
    expect_out("victory_sticky", 4'd15, 0, 8'd1, 1);
    play_selected = 1'b0; cyc(1);
    expect_out("victory_to_idle", 4'd15, 0, 8'd0, 0);

    // game_over on the same cycle as the expiry tick of phase 0.
    play_selected = 1'b1; cyc(1);
    frame(2); frame(2);
    vsync_in = 1'b1; game_over = 1'b1; cyc(1);
    vsync_in = 1'b0; game_over = 1'b0; cyc(1);
    expect_out("lost_phase0", 4'd15, 0, 8'd0, 0);
    frame(3);
    expect_out("lost_holds", 4'd15, 0, 8'd0, 0);
    play_selected = 1'b0; cyc(1);
    expect_out("lost_to_idle", 4'd15, 0, 8'd0, 0);

    // Loss in phase 1 keeps phase_num.
    play_selected = 1'b1; cyc(1);
    frame(2); frame(3); frame(2);
    expect_out("active1_again", 4'd1, 1, 8'd1, 0);
    game_over = 1'b1; cyc(1); game_over = 1'b0; cyc(1);
    expect_out("lost_phase1", 4'd15, 0, 8'd1, 0);
    frame(3);
    expect_out("lost_phase1_holds", 4'd15, 0, 8'd1, 0);
    play_selected = 1'b0; cyc(1);

    // play_selected drop beats game_over.
    play_selected = 1'b1; cyc(1); frame(2);
    play_selected = 1'b0; game_over = 1'b1; cyc(1);
    play_selected = 1'b1; game_over = 1'b0;
    expect_out("drop_beats_over", 4'd15, 0, 8'd0, 0);
    cyc(1); frame(2);
    expect_out("restart_active0", 4'd0, 1, 8'd0, 0);

    // Long vsync counts as a single tick.
    play_selected = 1'b0; cyc(1);
    play_selected = 1'b1; cyc(1);
    vsync_in = 1'b1; cyc(100); vsync_in = 1'b0; cyc(1);
    expect_out("long_vsync_one_tick", 4'd15, 0, 8'd0, 0);
    frame(1);
    expect_out("long_vsync_then_one", 4'd0, 1, 8'd0, 0);

    // Tick coinciding with play rising is not counted.
    play_selected = 1'b0; cyc(1);
    play_selected = 1'b1; vsync_in = 1'b1; cyc(1); vsync_in = 1'b0; cyc(1);
    frame(1);
    expect_out("start_tick_ignored", 4'd15, 0, 8'd0, 0);
    frame(1);
    expect_out("start_then_active", 4'd0, 1, 8'd0, 0);

    // Asynchronous reset between clock edges.
    frame(1);
    @(posedge pclk); #2 rst = 1'b0; #1;
    expect_out("async_reset", 4'd15, 0, 8'd0, 0);
    cyc(2); rst = 1'b1; cyc(1);
    expect_out("post_reset_gap", 4'd15, 0, 8'd0, 0);
    frame(1);
    expect_out("post_reset_gap_tick", 4'd15, 0, 8'd0, 0);
    frame(1);
    expect_out("post_reset_active", 4'd0, 1, 8'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
`else
  logic [3:0] prev_sel;
  bit         have_prev = 0;
  logic       prev_pa = 0;
  int         nphases = 0;

  always @(negedge pclk) begin
    if (phase_active && !prev_pa) begin
      checks++;
      if (obstacle_select > 4'd3 || (have_prev && obstacle_select == prev_sel)) begin
        errors++;
        $display("FAIL lfsr_phase%0d: got sel=%0d prev=%0d, want 0..3 and different", nphases, obstacle_select, prev_sel);
      end else begin
        $display("ok   lfsr_phase%0d: sel=%0d", nphases, obstacle_select);
      end
      prev_sel = obstacle_select; have_prev = 1; nphases++;
    end
    prev_pa = phase_active;
  end

  initial begin
    cyc(3);
    expect_out("reset", 4'd15, 0, 8'd0, 0);
    rst = 1'b1; cyc(1);
    play_selected = 1'b1; cyc(1);
    frame(NP * (GF + FPP) + 4);
    expect_out("lfsr_victory", 4'd15, 0, 8'(NP - 1), 1);
    checks++;
    if (nphases != NP) begin
      errors++;
      $display("FAIL lfsr_phase_count: got %0d, want %0d", nphases, NP);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
`endif

endmodule
